// File: rtl/decode_fwd.sv
// rtl/decode_fwd.sv - RV32I decode stage with operand bypass, load-use interlock and registered output
module decode_fwd #(
    parameter int XLEN = 32,
    parameter int RA_W = 5,
    parameter int NUM_FWD = 2,
    parameter int EX_W = 4,
    parameter logic [EX_W-1:0] EX_ILLEGAL = 4'd2,
    parameter int CNT_W = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [XLEN-1:0]           in_pc,
    input  logic [31:0]               in_instr,
    input  logic [EX_W-1:0]           in_ex,
    input  logic                      in_ex_valid,
    output logic [RA_W-1:0]           rs1_addr,
    input  logic [XLEN-1:0]           rs1_data,
    output logic [RA_W-1:0]           rs2_addr,
    input  logic [XLEN-1:0]           rs2_data,
    input  logic [NUM_FWD-1:0]        fwd_valid,
    input  logic [NUM_FWD-1:0]        fwd_busy,
    input  logic [NUM_FWD*RA_W-1:0]   fwd_addr,
    input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           out_pc,
    output logic [4:0]                out_opcode,
    output logic [2:0]                out_funct,
    output logic                      out_variant,
    output logic [XLEN-1:0]           out_op1,
    output logic [XLEN-1:0]           out_op2,
    output logic [XLEN-1:0]           out_offset,
    output logic [RA_W-1:0]           out_rd_addr,
    output logic                      out_nop,
    output logic [EX_W-1:0]           out_ex,
    output logic                      out_ex_valid,
    output logic [CNT_W-1:0]          perf_bubbles
);

    typedef enum logic [1:0] {SRC1_ZERO, SRC1_RS, SRC1_PC} src1_t;
    typedef enum logic [2:0] {SRC2_ZERO, SRC2_RS, SRC2_IMMI, SRC2_IMMU, SRC2_IMMJ} src2_t;

    // Immediates are assembled at 32 bits, then sign-extended to XLEN.
    function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
        return {{(XLEN-31){v[31]}}, v[30:0]};
    endfunction

    logic [4:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opc = in_instr[6:2];
    assign f3  = in_instr[14:12];
    assign f7  = in_instr[31:25];
    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u = {in_instr[31:12], 12'b0};
    assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    logic legal, kill, use1, use2, wr, funct_use, misc, variant;
    src1_t sel1;
    src2_t sel2;
    logic [XLEN-1:0] offset;

    always_comb begin
        legal = 1'b0;
        use1 = 1'b0;
        use2 = 1'b0;
        wr = 1'b0;
        funct_use = 1'b0;
        misc = 1'b0;
        variant = 1'b0;
        sel1 = SRC1_ZERO;
        sel2 = SRC2_ZERO;
        offset = '0;
        if (in_instr[1:0] == 2'b11) begin
            case (opc)
                5'b00100: begin
                    legal = 1'b1; use1 = 1'b1; wr = 1'b1; funct_use = 1'b1;
                    sel1 = SRC1_RS; sel2 = SRC2_IMMI;
                    variant = (f3 == 3'd1 || f3 == 3'd5) && f7[5];
                end
                5'b01100: begin
                    legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                    use1 = 1'b1; use2 = 1'b1; wr = 1'b1; funct_use = 1'b1;
                    sel1 = SRC1_RS; sel2 = SRC2_RS; variant = f7[5];
                end
                5'b01101: begin
                    legal = 1'b1; wr = 1'b1; sel2 = SRC2_IMMU;
                end
                5'b00101: begin
                    legal = 1'b1; wr = 1'b1; sel1 = SRC1_PC; sel2 = SRC2_IMMU;
                end
                5'b11011: begin
                    legal = 1'b1; wr = 1'b1; sel1 = SRC1_PC; sel2 = SRC2_IMMJ;
                end
                5'b11001: begin
                    legal = (f3 == 3'd0); use1 = 1'b1; wr = 1'b1; funct_use = 1'b1;
                    sel1 = SRC1_RS; sel2 = SRC2_IMMI;
                end
                5'b11000: begin
                    legal = 1'b1; use1 = 1'b1; use2 = 1'b1; funct_use = 1'b1;
                    sel1 = SRC1_RS; sel2 = SRC2_RS; offset = sext(imm_b);
                end
                5'b00000: begin
                    legal = 1'b1; use1 = 1'b1; wr = 1'b1; funct_use = 1'b1;
                    sel1 = SRC1_RS; sel2 = SRC2_IMMI;
                end
                5'b01000: begin
                    legal = 1'b1; use1 = 1'b1; use2 = 1'b1; funct_use = 1'b1;
                    sel1 = SRC1_RS; sel2 = SRC2_RS; offset = sext(imm_s);
                end
                5'b00011: begin
                    legal = 1'b1; misc = 1'b1; funct_use = 1'b1;
                end
                default: legal = 1'b0;
            endcase
        end
        // Exceptions read no registers, so they can never stall on a bypass source.
        kill = in_ex_valid || !legal;
        if (kill) begin
            use1 = 1'b0;
            use2 = 1'b0;
            wr = 1'b0;
            variant = 1'b0;
            sel1 = SRC1_ZERO;
            sel2 = SRC2_ZERO;
            offset = '0;
        end
    end

    assign rs1_addr = use1 ? in_instr[19:15] : '0;
    assign rs2_addr = use2 ? in_instr[24:20] : '0;

    logic [XLEN-1:0] val1, val2;
    logic busy1, busy2;

    // Scan oldest to youngest so the lowest matching index is the one that sticks.
    always_comb begin
        val1 = rs1_data;
        val2 = rs2_data;
        busy1 = 1'b0;
        busy2 = 1'b0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_valid[i] && fwd_addr[i*RA_W +: RA_W] == rs1_addr) begin
                val1 = fwd_data[i*XLEN +: XLEN];
                busy1 = fwd_busy[i];
            end
            if (fwd_valid[i] && fwd_addr[i*RA_W +: RA_W] == rs2_addr) begin
                val2 = fwd_data[i*XLEN +: XLEN];
                busy2 = fwd_busy[i];
            end
        end
        if (rs1_addr == '0) begin
            val1 = '0;
            busy1 = 1'b0;
        end
        if (rs2_addr == '0) begin
            val2 = '0;
            busy2 = 1'b0;
        end
    end

    logic hazard, slot_free, accept;
    assign hazard    = busy1 || busy2;
    assign slot_free = !out_valid || out_ready;
    assign in_ready  = !flush && !hazard && slot_free;
    assign accept    = in_valid && in_ready;

    logic [XLEN-1:0] op1_n, op2_n;

    always_comb begin
        case (sel1)
            SRC1_RS: op1_n = val1;
            SRC1_PC: op1_n = in_pc;
            default: op1_n = '0;
        endcase
        case (sel2)
            SRC2_RS:   op2_n = val2;
            SRC2_IMMI: op2_n = sext(imm_i);
            SRC2_IMMU: op2_n = sext(imm_u);
            SRC2_IMMJ: op2_n = sext(imm_j);
            default:   op2_n = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_opcode   <= '0;
            out_funct    <= '0;
            out_variant  <= 1'b0;
            out_op1      <= '0;
            out_op2      <= '0;
            out_offset   <= '0;
            out_rd_addr  <= '0;
            out_nop      <= 1'b0;
            out_ex       <= '0;
            out_ex_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            out_pc       <= in_pc;
            out_opcode   <= opc;
            out_funct    <= funct_use ? f3 : 3'd0;
            out_variant  <= variant;
            out_op1      <= op1_n;
            out_op2      <= op2_n;
            out_offset   <= offset;
            out_rd_addr  <= wr ? in_instr[11:7] : '0;
            out_nop      <= misc || kill;
            out_ex       <= in_ex_valid ? in_ex : (legal ? '0 : EX_ILLEGAL);
            out_ex_valid <= kill;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_bubbles <= '0;
        end else if (!flush && in_valid && hazard && slot_free) begin
            perf_bubbles <= perf_bubbles + CNT_W'(1);
        end
    end

endmodule
